mips_debug_unit: RTL and testbench
==================================

Name: mips_debug_unit

Overview:
- Host-side controller directly upstream of the MIPS pipeline top; drives its debug inputs (instruction-memory write, debug mode, single-step).
- Consumes byte strobes from a UART receiver and produces byte requests for a UART transmitter.
- Host can load program words, run, halt and single-step the core; after each step it reads back PC and write-back data.

Parameters:
- NB_BITS, 32, datapath / instruction word width
- NB_ADDR, 8, instruction-memory word-address width
- NB_BYTE, 8, UART byte width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_data  in  NB_BYTE  received byte, valid only with i_rx_valid
- i_rx_valid  in  1  one-cycle strobe, new byte available
- o_tx_data  out  NB_BYTE  byte to transmit, held stable until i_tx_done
- o_tx_start  out  1  one-cycle strobe, start transmission of o_tx_data
- i_tx_done  in  1  one-cycle strobe, transmitter finished current byte
- o_instr_data  out  NB_BITS  word to write into instruction memory
- o_instr_addr  out  NB_ADDR  word address for o_instr_data
- o_instr_we  out  1  instruction-memory write enable, one cycle per word
- o_debug  out  1  1 = core in debug (halted) mode; 0 = free run
- o_step  out  1  one-cycle pulse, advance core one clock while o_debug=1
- i_pc  in  NB_BITS  core PC (IF/ID)
- i_wb_data  in  NB_BITS  core write-back data

Behaviour:
- Reset (sync, i_rst=1 at clock edge):
  - state=IDLE; o_debug=1; all other outputs 0; internal counters/shift registers 0.
  - Reset mid-operation abandons any load or transmit; no partial writes complete.
- Commands are accepted only in IDLE, on i_rx_valid:
  - 0x4C 'L': load
  - 0x52 'R': run
  - 0x53 'S': step
  - any other byte: ignored, remain in IDLE
- States: IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SNAP, TX_SEND, TX_WAIT.
- LOAD:
  - IDLE -'L'-> LD_CNT. Next byte N = word count.
  - N=0: return to IDLE, no writes, no ack.
  - Otherwise LD_BYTE collects 4 bytes MSB-first into a word; on the 4th byte go to LD_WR.
  - LD_WR: o_instr_we=1 for exactly one cycle with o_instr_addr=k (k=0..N-1, starting at 0 each load) and o_instr_data=assembled word.
  - After word N-1: queue a single ack byte 0x4B 'K' -> TX_SEND; otherwise back to LD_BYTE.
  - o_debug stays 1 throughout the load.
- RUN:
  - IDLE -'R'-> RUN, o_debug=0 from the next cycle.
  - In RUN only byte 0x48 'H' is honoured: o_debug=1 the following cycle, state=IDLE. All other bytes are ignored.
- STEP:
  - IDLE -'S'-> STEP: o_step=1 for exactly one cycle.
  - SNAP, the next cycle: capture {i_pc, i_wb_data} into a 64-bit shift register, load byte count 8 -> TX_SEND.
- Transmit:
  - TX_SEND: o_tx_data = top byte (MSB first: PC[31:24] .. PC[7:0], then WB[31:24] .. WB[7:0]); o_tx_start=1 for one cycle -> TX_WAIT.
  - TX_WAIT: o_tx_data held. On i_tx_done, shift by 8 and decrement count; count=0 -> IDLE, else -> TX_SEND.
  - i_tx_done outside TX_WAIT is ignored.
- Received bytes outside IDLE, LD_CNT, LD_BYTE and RUN are dropped; there is no buffering.
- Simultaneous i_rx_valid and i_tx_done: each is handled only by the state that consumes it; never both in one state.
- o_instr_addr wraps modulo 2^NB_ADDR when N exceeds memory depth; no error is raised.
- Latency:
  - 'S' strobe to o_step: 1 cycle.
  - o_step to first o_tx_start: 2 cycles.
  - 4th load byte to o_instr_we: 1 cycle.

Test Plan:
- Reset check: hold i_rst 2 cycles -> o_debug=1, o_step=0, o_instr_we=0, o_tx_start=0.
- Load 2 words: send 4C, 02, 12 34 56 78, 9A BC DE F0 -> we pulses: (addr 0, 0x12345678), then (addr 1, 0x9ABCDEF0); then o_tx_start with o_tx_data=0x4B; final state IDLE.
- Zero-count load: send 4C, 00 -> no o_instr_we, no tx; a following 'S' is accepted.
- Single step: i_pc=0x00000004, i_wb_data=0xDEADBEEF, send 53 -> one o_step pulse; with i_tx_done returned 10 cycles after each start, bytes transmitted in order 00 00 00 04 DE AD BE EF.
- Run/halt: send 52 -> o_debug=0; send 53 -> ignored, no o_step; send 48 -> o_debug=1.
- Reset mid-load: assert i_rst after the 2nd data byte -> no o_instr_we; next load writes addr 0.

Source files
------------

// File: rtl/mips_debug_unit.sv
// mips_debug_unit: host-side debug controller for the MIPS pipeline.
// The host sends byte commands over UART to load program words, run, halt
// and single-step the core. After each step the unit streams back PC and
// write-back data, MSB first.
module mips_debug_unit #(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_BITS-1:0] o_instr_data,
  output logic [NB_ADDR-1:0] o_instr_addr,
  output logic               o_instr_we,
  output logic               o_debug,
  output logic               o_step,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic [NB_BITS-1:0] i_wb_data
);

  localparam int WORD_BYTES = NB_BITS / NB_BYTE;
  localparam int BC_W       = $clog2(WORD_BYTES);
  localparam int TX_W       = 2 * NB_BITS;
  localparam int TX_BYTES   = TX_W / NB_BYTE;
  localparam int TC_W       = $clog2(TX_BYTES + 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_HALT = NB_BYTE'(8'h48);
  localparam logic [NB_BYTE-1:0] ACK      = NB_BYTE'(8'h4B);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SNAP, TX_SEND, TX_WAIT
  } state_t;

  state_t state, state_nx;

  logic [NB_BYTE-1:0] words_left;  // words still to be written in this load
  logic [NB_ADDR-1:0] addr;        // wraps freely past memory depth
  logic [BC_W-1:0]    byte_cnt;
  logic [NB_BITS-1:0] word;
  logic [TX_W-1:0]    tx_sr;       // outgoing bytes, current byte on top
  logic [TC_W-1:0]    tx_cnt;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic; rx bytes and tx_done are only looked at by the states that use them
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_rx_valid) begin
        if      (i_rx_data == CMD_LOAD) state_nx = LD_CNT;
        else if (i_rx_data == CMD_RUN)  state_nx = RUN;
        else if (i_rx_data == CMD_STEP) state_nx = STEP;
      end
      LD_CNT:  if (i_rx_valid) state_nx = (i_rx_data == '0) ? IDLE : LD_BYTE;
      LD_BYTE: if (i_rx_valid && byte_cnt == BC_W'(WORD_BYTES - 1)) state_nx = LD_WR;
      LD_WR:   state_nx = (words_left == NB_BYTE'(1)) ? TX_SEND : LD_BYTE;
      RUN:     if (i_rx_valid && i_rx_data == CMD_HALT) state_nx = IDLE;
      STEP:    state_nx = SNAP;
      SNAP:    state_nx = TX_SEND;
      TX_SEND: state_nx = TX_WAIT;
      TX_WAIT: if (i_tx_done) state_nx = (tx_cnt == TC_W'(1)) ? IDLE : TX_SEND;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: word assembly, load addressing and transmit shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      words_left <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      tx_sr      <= '0;
      tx_cnt     <= '0;
    end else begin
      case (state)
        LD_CNT: if (i_rx_valid) begin
          words_left <= i_rx_data;
          addr       <= '0;
          byte_cnt   <= '0;
        end
        LD_BYTE: if (i_rx_valid) begin
          word     <= {word[NB_BITS-NB_BYTE-1:0], i_rx_data};
          byte_cnt <= byte_cnt + BC_W'(1);
        end
        LD_WR: begin
          words_left <= words_left - NB_BYTE'(1);
          addr       <= addr + NB_ADDR'(1);
          byte_cnt   <= '0;
          // last word: queue the single ack byte
          if (words_left == NB_BYTE'(1)) begin
            tx_sr  <= {ACK, {(TX_W-NB_BYTE){1'b0}}};
            tx_cnt <= TC_W'(1);
          end
        end
        SNAP: begin
          tx_sr  <= {i_pc, i_wb_data};
          tx_cnt <= TC_W'(TX_BYTES);
        end
        TX_WAIT: if (i_tx_done) begin
          tx_sr  <= tx_sr << NB_BYTE;
          tx_cnt <= tx_cnt - TC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from state; data outputs come straight from registers
  always_comb begin
    o_debug      = (state != RUN);
    o_step       = (state == STEP);
    o_instr_we   = (state == LD_WR);
    o_tx_start   = (state == TX_SEND);
    o_instr_addr = addr;
    o_instr_data = word;
    o_tx_data    = tx_sr[TX_W-1 -: NB_BYTE];
  end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Bench for mips_debug_unit: random loads/steps checked against a simple
// transaction model (expected write list and expected transmitted bytes).
module tb_mips_debug_unit;
  localparam int NB_BITS = 32;
  localparam int NB_ADDR = 4;   // small memory so wrap-around is reachable
  localparam int NB_BYTE = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NB_BYTE-1:0] rx_data = '0;
  logic               rx_valid = 1'b0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done = 1'b0;
  logic [NB_BITS-1:0] instr_data;
  logic [NB_ADDR-1:0] instr_addr;
  logic               instr_we;
  logic               debug;
  logic               step;
  logic [NB_BITS-1:0] pc = '0;
  logic [NB_BITS-1:0] wb = '0;

  mips_debug_unit #(.NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_instr_data(instr_data), .o_instr_addr(instr_addr), .o_instr_we(instr_we),
    .o_debug(debug), .o_step(step), .i_pc(pc), .i_wb_data(wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { logic [NB_ADDR-1:0] addr; logic [NB_BITS-1:0] data; } wr_t;
  wr_t        wq[$];
  logic [7:0] txq[$];
  int         steps = 0;
  int         step_cyc = 0;
  int         tx0_cyc = 0;
  bit         dbg_drop = 1'b0;

  // observe DUT outputs mid-cycle and log transactions
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (instr_we) begin
      w.addr = instr_addr;
      w.data = instr_data;
      wq.push_back(w);
    end
    if (tx_start) begin
      if (txq.size() == 0) tx0_cyc = cyc;
      txq.push_back(tx_data);
    end
    if (step) begin
      steps++;
      step_cyc = cyc;
    end
    if (!debug) dbg_drop = 1'b1;
  end

  // transmitter stand-in: done strobe 10 cycles after each start
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (10) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic clear();
    wq.delete(); txq.delete(); steps = 0; dbg_drop = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (txq.size() < n && t < 500) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if (txq.size() < n) begin
      $display("FAIL tx_timeout: got %0d bytes, need %0d", txq.size(), n);
      n_fail++;
    end
    repeat (14) @(negedge clk);  // let the last done strobe land
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (debug !== 1'b1 || step !== 1'b0 || instr_we !== 1'b0 || tx_start !== 1'b0) begin
      $display("FAIL reset_ctrl: debug=%b step=%b we=%b start=%b, need 1 0 0 0",
               debug, step, instr_we, tx_start);
      n_fail++;
    end
    n_checks++;
    if (tx_data !== '0 || instr_data !== '0 || instr_addr !== '0) begin
      $display("FAIL reset_data: tx=%h idata=%h iaddr=%h, need all zero",
               tx_data, instr_data, instr_addr);
      n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_load(input int n, input bit use_plan);
    logic [NB_BITS-1:0] words[];
    logic [NB_BITS-1:0] w;
    words = new[n];
    for (int k = 0; k < n; k++) words[k] = $urandom;
    if (use_plan) begin
      words[0] = 32'h12345678;
      words[1] = 32'h9ABCDEF0;
    end
    clear();
    send(8'h4C);
    send(8'(n));
    for (int k = 0; k < n; k++) begin
      w = words[k];
      for (int b = 0; b < 4; b++) send(w[31-8*b -: 8]);
      n_checks++;
      if (instr_we !== 1'b1) begin
        $display("FAIL load_we_latency word %0d: we=%b, need 1", k, instr_we);
        n_fail++;
      end
    end
    wait_tx(1);
    n_checks++;
    if (wq.size() != n) begin
      $display("FAIL load_count: %0d writes, need %0d", wq.size(), n);
      n_fail++;
    end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      n_checks++;
      if (wq[k].addr !== NB_ADDR'(k) || wq[k].data !== words[k]) begin
        $display("FAIL load_write %0d: addr=%0d data=%h, need addr=%0d data=%h",
                 k, wq[k].addr, wq[k].data, NB_ADDR'(k), words[k]);
        n_fail++;
      end
    end
    n_checks++;
    if (txq.size() != 1 || txq[0] !== 8'h4B) begin
      $display("FAIL load_ack: %0d bytes first=%h, need 1 byte 4b",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
      n_fail++;
    end
    n_checks++;
    if (dbg_drop) begin
      $display("FAIL load_debug: debug dropped to 0 during load, need 1");
      n_fail++;
    end
  endtask

  task automatic test_step(input logic [31:0] p, input logic [31:0] d);
    logic [63:0] m;
    m = {p, d};
    clear();
    pc = p; wb = d;
    send(8'h53);
    wait_tx(8);
    n_checks++;
    if (steps != 1) begin
      $display("FAIL step_pulses: %0d, need 1", steps);
      n_fail++;
    end
    n_checks++;
    if (tx0_cyc - step_cyc != 2) begin
      $display("FAIL step_tx_latency: %0d cycles, need 2", tx0_cyc - step_cyc);
      n_fail++;
    end
    n_checks++;
    if (txq.size() != 8) begin
      $display("FAIL step_bytes: %0d bytes, need 8", txq.size());
      n_fail++;
    end
    for (int i = 0; i < 8 && i < txq.size(); i++) begin
      n_checks++;
      if (txq[i] !== m[63-8*i -: 8]) begin
        $display("FAIL step_byte %0d: got %h, need %h", i, txq[i], m[63-8*i -: 8]);
        n_fail++;
      end
    end
  endtask

  task automatic test_zero_load();
    clear();
    send(8'h4C);
    send(8'h00);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wq.size() != 0 || txq.size() != 0) begin
      $display("FAIL zero_load: writes=%0d tx=%0d, need 0 0", wq.size(), txq.size());
      n_fail++;
    end
    test_step($urandom, $urandom);
  endtask

  task automatic test_garbage();
    logic [7:0] b;
    clear();
    for (int i = 0; i < 10; i++) begin
      do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
      send(b);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (wq.size() != 0 || txq.size() != 0 || steps != 0 || dbg_drop) begin
      $display("FAIL garbage_idle: writes=%0d tx=%0d steps=%0d dbgdrop=%b, need 0 0 0 0",
               wq.size(), txq.size(), steps, dbg_drop);
      n_fail++;
    end
  endtask

  task automatic test_run_halt();
    logic [7:0] b;
    clear();
    send(8'h52);
    n_checks++;
    if (debug !== 1'b0) begin
      $display("FAIL run_debug: debug=%b, need 0", debug);
      n_fail++;
    end
    send(8'h53);
    send(8'h4C);
    for (int i = 0; i < 4; i++) begin
      do b = 8'($urandom); while (b == 8'h48);
      send(b);
    end
    n_checks++;
    if (debug !== 1'b0 || steps != 0 || wq.size() != 0 || txq.size() != 0) begin
      $display("FAIL run_ignore: debug=%b steps=%0d writes=%0d tx=%0d, need 0 0 0 0",
               debug, steps, wq.size(), txq.size());
      n_fail++;
    end
    send(8'h48);
    n_checks++;
    if (debug !== 1'b1) begin
      $display("FAIL halt_debug: debug=%b, need 1", debug);
      n_fail++;
    end
    test_step($urandom, $urandom);
  endtask

  task automatic test_rx_in_tx();
    int t = 0;
    clear();
    pc = $urandom; wb = $urandom;
    send(8'h53);
    while (txq.size() < 1 && t < 50) begin
      @(negedge clk); t++;
    end
    send(8'h53);  // arrives in TX_WAIT: must be dropped
    send(8'h4C);
    wait_tx(8);
    repeat (10) @(negedge clk);
    n_checks++;
    if (steps != 1 || txq.size() != 8 || wq.size() != 0) begin
      $display("FAIL rx_in_tx: steps=%0d tx=%0d writes=%0d, need 1 8 0",
               steps, txq.size(), wq.size());
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_load();
    clear();
    send(8'h4C);
    send(8'h02);
    send(8'($urandom));
    send(8'($urandom));
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wq.size() != 0 || txq.size() != 0) begin
      $display("FAIL reset_mid_load: writes=%0d tx=%0d, need 0 0", wq.size(), txq.size());
      n_fail++;
    end
    test_load(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load(2, 1'b1);
    test_zero_load();
    test_step(32'h00000004, 32'hDEADBEEF);
    test_garbage();
    test_run_halt();
    for (int i = 0; i < 3; i++) test_load(int'($urandom_range(1, 5)), 1'b0);
    for (int i = 0; i < 2; i++) test_step($urandom, $urandom);
    test_rx_in_tx();
    test_reset_mid_load();
    test_load(18, 1'b0);  // address wraps past 16 words
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
